// File: rtl/bsa_pkg.sv
// Shared constants for the bit-serial adder: default width, counter sizing and mode encodings.
package bsa_pkg;

  localparam int unsigned BSA_WIDTH = 8;

  // Counter must reach WIDTH itself, which marks idle/done.
  function automatic int unsigned bsa_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = bsa_cnt_w(BSA_WIDTH);

  localparam logic MODE_LOAD = 1'b1;
  localparam logic MODE_RUN  = 1'b0;

endpackage

// File: rtl/bsa_full_adder.sv
// Single-bit combinational full adder used as the serial arithmetic core.
module bsa_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder computed LSB-first, one bit per clock through one full adder.
// Define BSA_DONE_EN to add a `done` output that is high while the counter sits at WIDTH.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int unsigned WIDTH = BSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef BSA_DONE_EN
  ,
  output logic             done
`endif
);

  localparam int unsigned CntW = bsa_cnt_w(WIDTH);
  localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);

  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_s, fa_cout;

  bsa_full_adder u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (mode == MODE_LOAD) begin
      // A load always wins over an in-flight add, discarding its partial state.
      sh_a_d  = A;
      sh_b_d  = B;
      sum_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (cnt_q < CntFull) begin
      sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
      sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      carry_d = fa_cout;
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= CntFull;
    end else begin
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = carry_q;

`ifdef BSA_DONE_EN
  assign done = (cnt_q == CntFull);
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: vector table, spec corner sequences, random adds.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Sum;
  logic         Cout;
`ifdef BSA_DONE_EN
  logic         done;
`endif

  int checks   = 0;
  int failures = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .A     (A),
    .B     (B),
    .Sum   (Sum),
    .Cout  (Cout)
`ifdef BSA_DONE_EN
    ,
    .done  (done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: after k shift edges the low k bits of A+B sit in Sum's top k bits and
  // Cout is the carry out of the low k bits.
  task automatic check_partial(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int k);
    int unsigned m, lo, exp_sum, exp_cout;
    m        = (1 << k) - 1;
    lo       = (int'(a) & m) + (int'(b) & m);
    exp_sum  = ((lo & m) << (W - k)) & 32'hff;
    exp_cout = (lo >> k) & 1;
    check({name, " sum"}, 32'(Sum), exp_sum);
    check({name, " cout"}, 32'(Cout), exp_cout);
`ifdef BSA_DONE_EN
    check({name, " done"}, 32'(done), (k == W) ? 1 : 0);
`endif
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    mode = 1'b1;
    A    = a;
    B    = b;
    tick();
    mode = 1'b0;
    A    = ~a;
    B    = ~b;
  endtask

  // Full add with partial-result checks on every edge plus a post-completion hold edge.
  task automatic run_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    load(a, b);
    check_partial({name, " k0"}, a, b, 0);
    for (int k = 1; k <= W; k++) begin
      tick();
      check_partial({name, " k"}, a, b, k);
    end
    tick();
    check_partial({name, " hold"}, a, b, W);
  endtask

  initial begin
    vecs[0] = '{a: 8'd35,  b: 8'd26,  exp_sum: 8'd61,  exp_cout: 1'b0};
    vecs[1] = '{a: 8'd205, b: 8'd67,  exp_sum: 8'd16,  exp_cout: 1'b1};
    vecs[2] = '{a: 8'd205, b: 8'd159, exp_sum: 8'd108, exp_cout: 1'b1};
    vecs[3] = '{a: 8'd187, b: 8'd131, exp_sum: 8'd62,  exp_cout: 1'b1};
    vecs[4] = '{a: 8'd50,  b: 8'd156, exp_sum: 8'd206, exp_cout: 1'b0};
    vecs[5] = '{a: 8'd9,   b: 8'd21,  exp_sum: 8'd30,  exp_cout: 1'b0};
    vecs[6] = '{a: 8'd255, b: 8'd1,   exp_sum: 8'd0,   exp_cout: 1'b1};
    vecs[7] = '{a: 8'd0,   b: 8'd0,   exp_sum: 8'd0,   exp_cout: 1'b0};
    vecs[8] = '{a: 8'd255, b: 8'd255, exp_sum: 8'd254, exp_cout: 1'b1};

    reset = 1'b0;
    mode  = 1'b0;
    A     = 8'hA5;
    B     = 8'h5A;
    tick();
    tick();
    check("reset sum", 32'(Sum), 0);
    check("reset cout", 32'(Cout), 0);
`ifdef BSA_DONE_EN
    check("reset done", 32'(done), 1);
`endif
    reset = 1'b1;
    tick();
    tick();
    check("idle sum", 32'(Sum), 0);
    check("idle cout", 32'(Cout), 0);

    // Table: load, WIDTH shifts, then one extra edge which must not disturb the result.
    foreach (vecs[i]) begin
      load(vecs[i].a, vecs[i].b);
      repeat (W) tick();
      check($sformatf("vec%0d sum", i), 32'(Sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d cout", i), 32'(Cout), 32'(vecs[i].exp_cout));
      tick();
      check($sformatf("vec%0d hold sum", i), 32'(Sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d hold cout", i), 32'(Cout), 32'(vecs[i].exp_cout));
    end

    run_add("35+26", 8'd35, 8'd26);

    // Reset mid-operation returns to idle with a cleared result.
    load(8'd4, 8'd1);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset sum", 32'(Sum), 0);
    check("midreset cout", 32'(Cout), 0);
`ifdef BSA_DONE_EN
    check("midreset done", 32'(done), 1);
`endif
    tick();
    check("midreset idle sum", 32'(Sum), 0);
    run_add("9+21", 8'd9, 8'd21);

    // Reload while busy restarts cleanly.
    load(8'd55, 8'd67);
    repeat (4) tick();
    run_add("abort 255+1", 8'd255, 8'd1);

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run_add($sformatf("rnd%0d", n), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
